// File: rtl/dsi_tx_pkg.sv
// Shared definitions for the DSI transmit packet path: states, data IDs,
// CRC-16 constants and the header ECC / CRC byte helpers.
package dsi_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } pkt_state_e;

  typedef logic [31:0] pkt_word_t;
  typedef logic [3:0]  pkt_strb_t;

  // Long-packet data IDs on virtual channel 0
  localparam logic [7:0] DI_RGB888      = 8'h3E;
  localparam logic [7:0] DI_RGB666_LOOSE = 8'h2E;
  localparam logic [7:0] DI_RGB666      = 8'h1E;

  // CRC-16 x^16+x^12+x^5+1, reflected form, no final XOR
  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Word counter wide enough for 65532/4 words
  localparam int CNT_W = 14;

  // 6-bit Hamming ECC over the 24 header bits {WC_hi, WC_lo, DI}; bits 7:6 are zero
  function automatic logic [7:0] dsi_ecc24(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // Advance the CRC over one byte, bit 0 first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/dsi_tx_line_packetizer_if.sv
// Byte-packed packet word stream toward the lane distributor.
interface dsi_tx_line_packetizer_if;
  import dsi_tx_pkg::*;

  pkt_word_t pkt_data;   // byte 0 in [7:0]
  pkt_strb_t pkt_strb;   // valid-byte mask
  logic      pkt_valid;
  logic      pkt_last;
  logic      pkt_ready;

  modport master (output pkt_data, pkt_strb, pkt_valid, pkt_last, input pkt_ready);
  modport slave  (input pkt_data, pkt_strb, pkt_valid, pkt_last, output pkt_ready);
endinterface

// File: rtl/dsi_tx_crc16_x4.sv
// Combinational next-CRC over one 32-bit word, bytes 0..3 in order.
// Also used by the command packet path.
module dsi_tx_crc16_x4
  import dsi_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // Chain four byte steps into one single-cycle XOR network
  always_comb begin
    c = crc_in;
    for (int k = 0; k < 4; k++) begin
      c = crc16_byte(c, data[8*k +: 8]);
    end
    crc_out = c;
  end

endmodule

// File: rtl/dsi_tx_line_packetizer.sv
// Wraps one video line from the show-ahead pixel FIFO into a DSI long
// packet: header word (DI, WC, ECC), payload words, then the CRC-16 word.
module dsi_tx_line_packetizer
  import dsi_tx_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 1920,
  parameter logic [7:0]  DATA_ID    = DI_RGB888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_req,
  output logic        line_busy,
  output logic        line_done,
  input  logic [31:0] fifo_data,
  input  logic        fifo_not_empty,
  input  logic        fifo_line_ready,
  output logic        fifo_read_ack,
  dsi_tx_line_packetizer_if.master pkt,
  output logic        underflow_err
);

  localparam logic [15:0]      WC       = 16'(LINE_BYTES);
  localparam logic [CNT_W-1:0] WORDS    = CNT_W'(LINE_BYTES / 4);
  localparam logic [31:0]      HDR_WORD = {dsi_ecc24({WC, DATA_ID}), WC, DATA_ID};

  pkt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      crc_q, crc_d;
  logic [15:0]      crc_next;

  pkt_word_t data_o;
  pkt_strb_t strb_o;
  logic      valid_o, last_o;

  dsi_tx_crc16_x4 u_crc (
    .crc_in  (crc_q),
    .data    (fifo_data),
    .crc_out (crc_next)
  );

  // State, word counter and running CRC; reset aborts any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
    end
  end

  // Next state and all outputs; outputs are pure functions of state,
  // registers and the FIFO head so they hold while the stream is stalled
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    crc_d         = crc_q;
    data_o        = '0;
    strb_o        = '0;
    valid_o       = 1'b0;
    last_o        = 1'b0;
    fifo_read_ack = 1'b0;
    line_done     = 1'b0;
    underflow_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A request without a full line buffered is dropped, not queued
        if (line_req && fifo_line_ready) begin
          state_d = ST_HEADER;
          cnt_d   = WORDS;
          crc_d   = CRC_INIT;
        end
      end
      ST_HEADER: begin
        data_o  = HDR_WORD;
        strb_o  = 4'hF;
        valid_o = 1'b1;
        if (pkt.pkt_ready) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        data_o        = fifo_data;
        strb_o        = 4'hF;
        valid_o       = fifo_not_empty;
        // Stall on an empty FIFO rather than pad; flag every starved cycle
        underflow_err = !fifo_not_empty;
        if (fifo_not_empty && pkt.pkt_ready) begin
          fifo_read_ack = 1'b1;
          crc_d         = crc_next;
          cnt_d         = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        data_o  = {16'h0, crc_q};
        strb_o  = 4'b0011;
        valid_o = 1'b1;
        last_o  = 1'b1;
        if (pkt.pkt_ready) begin
          line_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign line_busy     = (state_q != ST_IDLE);
  assign pkt.pkt_data  = data_o;
  assign pkt.pkt_strb  = strb_o;
  assign pkt.pkt_valid = valid_o;
  assign pkt.pkt_last  = last_o;

endmodule
